return_addr_stack: RTL and testbench

//  Parametrised hardware return-address stack for the MUSA core: CALL pushes the return PC,
//  RET pops it. Successor to the fixed 18-bit stack: configurable width/depth, clocked,

---
 rtl/musa_ras_pkg.sv | 26 ++
 rtl/ras_mem.sv | 24 ++
 rtl/return_addr_stack.sv | 130 +++++++++++++
 tb/tb_return_addr_stack.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/musa_ras_pkg.sv
// Shared types for the MUSA return-address stack: default sizes, the PC type
// and the operation decoded from the push/pop strobes.
package musa_ras_pkg;

    localparam int RAS_PC_W  = 18;
    localparam int RAS_DEPTH = 8;

    typedef logic [RAS_PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        RAS_NOP  = 2'd0,
        RAS_PUSH = 2'd1,
        RAS_POP  = 2'd2,
        RAS_REPL = 2'd3
    } ras_op_e;

    function automatic ras_op_e ras_decode(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return RAS_PUSH;
            2'b01:   return RAS_POP;
            2'b11:   return RAS_REPL;
            default: return RAS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ras_mem.sv
// Return-address storage: DEPTH x PC_W registers, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module ras_mem #(
    parameter int PC_W  = 18,
    parameter int DEPTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [PC_W-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [PC_W-1:0] rdata_o
);

    logic [PC_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack: pointer, occupancy and sticky error flags around ras_mem.
// Define RAS_WRAP_EN for circular mode (push while full overwrites the oldest entry).
module return_addr_stack
    import musa_ras_pkg::*;
#(
    parameter int PC_W  = RAS_PC_W,
    parameter int DEPTH = RAS_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [PC_W-1:0]  push_pc,
    input  logic             flush,
    input  logic             clr_err,
    output logic [PC_W-1:0]  top_pc,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, top_idx, waddr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             ovf_ev, unf_ev, we;
    logic [PC_W-1:0]  rdata;
    ras_op_e          op;

    assign op      = ras_decode(push, pop);
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign count   = cnt_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

    // ptr names the next free slot, so the top lives one below it (mod DEPTH)
    assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    assign top_idx = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_W'(1);
    assign top_pc  = empty ? '0 : rdata;

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        we     = 1'b0;
        waddr  = ptr_q;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        unique case (op)
            RAS_PUSH: begin
                if (!full) begin
                    we    = 1'b1;
                    ptr_d = ptr_inc;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
`ifdef RAS_WRAP_EN
                    // slot at ptr holds the oldest entry once full
                    we    = 1'b1;
                    ptr_d = ptr_inc;
`else
                    ovf_ev = 1'b1;
`endif
                end
            end
            RAS_POP: begin
                if (!empty) begin
                    ptr_d = top_idx;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    unf_ev = 1'b1;
                end
            end
            RAS_REPL: begin
                if (!empty) begin
                    we    = 1'b1;
                    waddr = top_idx;
                end else begin
                    we     = 1'b1;
                    ptr_d  = ptr_inc;
                    cnt_d  = cnt_q + CNT_W'(1);
                    unf_ev = 1'b1;
                end
            end
            default: ;
        endcase
        ovf_d = ovf_ev | (ovf_q & ~clr_err);
        unf_d = unf_ev | (unf_q & ~clr_err);
        if (flush) begin
            ptr_d = '0;
            cnt_d = '0;
            we    = 1'b0;
            ovf_d = ovf_q;
            unf_d = unf_q;
        end
        if (!rst_n) we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ras_mem #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (push_pc),
        .raddr_i (top_idx),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_return_addr_stack.sv
// Scoreboard bench for return_addr_stack (DEPTH=4): a queue-based stack model
// predicts each cycle's outputs; a monitor compares them after every edge.
module tb_return_addr_stack;

    localparam int PC_W  = 18;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n, push, pop, flush, clr_err;
    logic [PC_W-1:0]  push_pc;
    logic [PC_W-1:0]  top_pc;
    logic [CNT_W-1:0] count;
    logic             empty, full, ovf_err, unf_err;

    always #5 clk = ~clk;

    return_addr_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .push_pc (push_pc),
        .flush   (flush),
        .clr_err (clr_err),
        .top_pc  (top_pc),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .ovf_err (ovf_err),
        .unf_err (unf_err)
    );

    typedef struct packed {
        logic [PC_W-1:0]  top;
        logic [CNT_W-1:0] cnt;
        logic             emp;
        logic             ful;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;
    bit    stim_done = 1'b0;

    // reference model: plain queue of addresses, newest at the back
    logic [PC_W-1:0] stk[$];
    logic            m_ovf, m_unf;

    task automatic step(input string nm, input logic r, input logic pu, input logic po,
                        input logic fl, input logic cl, input logic [PC_W-1:0] pc);
        exp_t e;
        logic eo, eu;
        @(negedge clk);
        rst_n = ~r; push = pu; pop = po; flush = fl; clr_err = cl; push_pc = pc;
        eo = 1'b0; eu = 1'b0;
        if (r) begin
            stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (fl) begin
            stk.delete();
        end else begin
            if (pu && po) begin
                if (stk.size() > 0) stk[stk.size()-1] = pc;
                else begin stk.push_back(pc); eu = 1'b1; end
            end else if (pu) begin
                if (stk.size() < DEPTH) stk.push_back(pc);
                else begin
`ifdef RAS_WRAP_EN
                    void'(stk.pop_front());
                    stk.push_back(pc);
`else
                    eo = 1'b1;
`endif
                end
            end else if (po) begin
                if (stk.size() > 0) void'(stk.pop_back());
                else eu = 1'b1;
            end
            m_ovf = eo | (m_ovf & ~cl);
            m_unf = eu | (m_unf & ~cl);
        end
        e.top = (stk.size() > 0) ? stk[stk.size()-1] : '0;
        e.cnt = CNT_W'(stk.size());
        e.emp = (stk.size() == 0);
        e.ful = (stk.size() == DEPTH);
        e.ovf = m_ovf;
        e.unf = m_unf;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // monitor: every edge that followed an issued operation is checked
    initial begin
        exp_t  e, a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{top: top_pc, cnt: count, emp: empty, ful: full, ovf: ovf_err, unf: unf_err};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got top=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b, expected top=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b",
                             nm, a.top, a.cnt, a.emp, a.ful, a.ovf, a.unf,
                             e.top, e.cnt, e.emp, e.ful, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; push_pc = '0;
        m_ovf = 1'b0; m_unf = 1'b0;

        step("reset_with_push", 1, 1, 0, 0, 0, 18'h12345);
        step("lifo_push_a11", 0, 1, 0, 0, 0, 18'h00A11);
        step("lifo_push_b22", 0, 1, 0, 0, 0, 18'h00B22);
        step("lifo_push_c33", 0, 1, 0, 0, 0, 18'h00C33);
        for (int i = 0; i < 3; i++) step("lifo_pop", 0, 0, 1, 0, 0, '0);

        step("unf_pop_empty", 0, 0, 1, 0, 0, '0);
        step("unf_clr", 0, 0, 0, 0, 1, '0);
        step("unf_clr_and_pop", 0, 0, 1, 0, 1, '0);
        step("unf_clr2", 0, 0, 0, 0, 1, '0);

        for (int i = 1; i <= 5; i++) step("full_push", 0, 1, 0, 0, 0, PC_W'(i));
        step("full_replace", 0, 1, 1, 0, 0, 18'h0ABCD);
        for (int i = 0; i < 5; i++) step("full_drain", 0, 0, 1, 0, 0, '0);
        step("err_clr", 0, 0, 0, 0, 1, '0);

        step("repl_push_111", 0, 1, 0, 0, 0, 18'h00111);
        step("repl_222", 0, 1, 1, 0, 0, 18'h00222);
        step("repl_pop", 0, 0, 1, 0, 0, '0);
        step("repl_on_empty", 0, 1, 1, 0, 0, 18'h00333);
        step("repl_clr", 0, 0, 0, 0, 1, '0);

        for (int i = 0; i < 3; i++) step("flush_fill", 0, 1, 0, 0, 0, PC_W'(18'h100 + i));
        step("flush_with_push", 0, 1, 0, 1, 0, 18'h01234);
        step("push_after_flush", 0, 1, 0, 0, 0, 18'h3FFFF);

        for (int i = 0; i < 600; i++) begin
            logic r, fl, cl, pu, po;
            r  = ($urandom_range(63) == 0);
            fl = ($urandom_range(31) == 0);
            cl = ($urandom_range(7) == 0);
            pu = $urandom_range(1);
            po = $urandom_range(1);
            step("random", r, pu, po, fl, cl, PC_W'($urandom));
        end

        @(negedge clk);
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, stim_done=%b", stim_done);
        $fatal(1, "timeout");
    end

endmodule
